// File: rtl/nonce_hub_arbiter.sv
// Shares one upstream serial transmitter among NUM_SLAVES nonce receivers.
// Each slave has a one-entry holding register, and a round-robin scheduler drives the start/busy handshake.
module nonce_hub_arbiter #(
    parameter int NUM_SLAVES   = 4,
    parameter int BUSY_TIMEOUT = 16
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic [32*NUM_SLAVES-1:0]  i_slave_nonce,
    input  logic [NUM_SLAVES-1:0]     i_slave_new_nonce,
    input  logic                      i_tx_busy,
    output logic [31:0]               o_tx_word,
    output logic                      o_tx_start,
    output logic [3:0]                o_tx_slave,
    output logic [NUM_SLAVES-1:0]     o_overflow
);
    localparam int IW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam int CW = $clog2(BUSY_TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, WAIT_BUSY, WAIT_DONE} state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [31:0]           r_hold [NUM_SLAVES];
    logic [NUM_SLAVES-1:0] r_pending;
    logic [NUM_SLAVES-1:0] r_overflow;
    logic [3:0]            r_last_grant;
    logic [CW-1:0]         r_count;
    logic [31:0]           r_tx_word;
    logic                  r_tx_start;
    logic [3:0]            r_tx_slave;

    logic                  w_found;
    logic                  w_grant_valid;
    logic [3:0]            w_sel;
    logic [4:0]            w_idx;
    logic [NUM_SLAVES-1:0] w_grant_vec;
    logic [NUM_SLAVES-1:0] w_load;
    logic [NUM_SLAVES-1:0] w_drop;
    logic [NUM_SLAVES-1:0] w_pending_next;

    // Round-robin search: first pending index strictly after the last grant, wrapping.
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        w_idx   = '0;
        for (int k = 1; k <= NUM_SLAVES; k++) begin
            w_idx = 5'(r_last_grant) + 5'(k);
            if (w_idx >= 5'(NUM_SLAVES)) begin
                w_idx = w_idx - 5'(NUM_SLAVES);
            end
            if (!w_found && r_pending[w_idx[IW-1:0]]) begin
                w_found = 1'b1;
                w_sel   = 4'(w_idx);
            end
        end
    end

    assign w_grant_valid = (r_state == IDLE) && w_found;

    // A slave being granted this cycle can accept a fresh word, because its old one leaves now.
    for (genvar gi = 0; gi < NUM_SLAVES; gi++) begin : g_slave
        assign w_grant_vec[gi]    = w_grant_valid && (w_sel == 4'(gi));
        assign w_load[gi]         = i_slave_new_nonce[gi] && (!r_pending[gi] || w_grant_vec[gi]);
        assign w_drop[gi]         = i_slave_new_nonce[gi] && r_pending[gi] && !w_grant_vec[gi];
        assign w_pending_next[gi] = i_slave_new_nonce[gi] ? 1'b1
                                  : (w_grant_vec[gi] ? 1'b0 : r_pending[gi]);
    end

    always_ff @(posedge i_clk) begin
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (w_load[i]) begin
                r_hold[i] <= i_slave_nonce[32*i +: 32];
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_pending  <= '0;
            r_overflow <= '0;
        end else begin
            r_pending  <= w_pending_next;
            r_overflow <= r_overflow | w_drop;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_grant_valid) begin
                    w_state_next = WAIT_BUSY;
                end
            end
            WAIT_BUSY: begin
                if (i_tx_busy) begin
                    w_state_next = WAIT_DONE;
                end else if (r_count == CW'(BUSY_TIMEOUT - 1)) begin
                    w_state_next = IDLE;
                end
            end
            WAIT_DONE: begin
                if (!i_tx_busy) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // A word abandoned on timeout is treated as consumed, so it is never retried.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_tx_word    <= '0;
            r_tx_start   <= 1'b0;
            r_tx_slave   <= '0;
            r_last_grant <= 4'(NUM_SLAVES - 1);
            r_count      <= '0;
        end else begin
            r_tx_start <= w_grant_valid;
            if (w_grant_valid) begin
                r_tx_word    <= r_hold[w_sel[IW-1:0]];
                r_tx_slave   <= w_sel;
                r_last_grant <= w_sel;
                r_count      <= '0;
            end else if (r_state == WAIT_BUSY && !i_tx_busy) begin
                r_count <= r_count + CW'(1);
            end
        end
    end

    assign o_tx_word  = r_tx_word;
    assign o_tx_start = r_tx_start;
    assign o_tx_slave = r_tx_slave;
    assign o_overflow = r_overflow;

endmodule

// File: tb/tb_nonce_hub_arbiter.sv
// Directed bench for nonce_hub_arbiter: a transaction-level model is compared against the DUT on every cycle.
// A start log is also checked against hand-computed literals.
module tb_nonce_hub_arbiter;
    localparam int N  = 4;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          i_reset = 1'b0;
    logic [32*N-1:0] i_slave_nonce = '0;
    logic [N-1:0]  i_slave_new_nonce = '0;
    logic          i_tx_busy = 1'b0;
    logic [31:0]   o_tx_word;
    logic          o_tx_start;
    logic [3:0]    o_tx_slave;
    logic [N-1:0]  o_overflow;

    nonce_hub_arbiter #(.NUM_SLAVES(N), .BUSY_TIMEOUT(TO)) dut (
        .i_clk             (clk),
        .i_reset           (i_reset),
        .i_slave_nonce     (i_slave_nonce),
        .i_slave_new_nonce (i_slave_new_nonce),
        .i_tx_busy         (i_tx_busy),
        .o_tx_word         (o_tx_word),
        .o_tx_start        (o_tx_start),
        .o_tx_slave        (o_tx_slave),
        .o_overflow        (o_overflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit cmp_en = 1'b0;
    bit tx_enable = 1'b1;
    int busy_cnt = 0;

    int          st_slave[$];
    logic [31:0] st_word[$];
    int          st_cyc[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Transaction-level model: holding slots, a rotating pointer, and a channel that is either free or busy.
    logic [31:0] m_hold [N];
    bit   [N-1:0] m_pending = '0;
    logic [N-1:0] m_ovf = '0;
    int   m_last = N - 1;
    bit   m_idle = 1'b1;
    bit   m_seen_busy = 1'b0;
    int   m_grant_cyc = 0;
    bit   m_start = 1'b0;
    logic [31:0] m_word = '0;
    int   m_slave = 0;
    int   m_sel;

    always @(posedge clk or posedge i_reset) begin
        if (i_reset) begin
            m_pending = '0;
            m_ovf     = '0;
            m_last    = N - 1;
            m_idle    = 1'b1;
            m_start   = 1'b0;
            m_word    = '0;
            m_slave   = 0;
        end else begin
            cyc++;
            m_start = 1'b0;
            m_sel   = -1;
            if (m_idle) begin
                for (int k = 1; k <= N; k++) begin
                    if (m_sel < 0 && m_pending[(m_last + k) % N]) m_sel = (m_last + k) % N;
                end
                if (m_sel >= 0) begin
                    m_word = m_hold[m_sel];
                    m_slave = m_sel;
                    m_start = 1'b1;
                    m_last = m_sel;
                    m_pending[m_sel] = 1'b0;
                    m_idle = 1'b0;
                    m_seen_busy = 1'b0;
                    m_grant_cyc = cyc;
                end
            end else if (!m_seen_busy) begin
                if (i_tx_busy) m_seen_busy = 1'b1;
                else if (cyc - m_grant_cyc == TO) m_idle = 1'b1;
            end else if (!i_tx_busy) begin
                m_idle = 1'b1;
            end
            for (int i = 0; i < N; i++) begin
                if (i_slave_new_nonce[i]) begin
                    if (m_pending[i]) m_ovf[i] = 1'b1;
                    else begin
                        m_hold[i] = i_slave_nonce[32*i +: 32];
                        m_pending[i] = 1'b1;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("tx_start", 64'(o_tx_start), 64'(m_start));
            chk("tx_word", 64'(o_tx_word), 64'(m_word));
            chk("tx_slave", 64'(o_tx_slave), 64'(m_slave));
            chk("overflow", 64'(o_overflow), 64'(m_ovf));
            if (o_tx_start) begin
                st_slave.push_back(int'(o_tx_slave));
                st_word.push_back(o_tx_word);
                st_cyc.push_back(cyc);
                $display("start: cycle %0d slave %0d word %08h", cyc, o_tx_slave, o_tx_word);
            end
        end
    end

    // Transmitter: busy rises the cycle after tx_start and stays high for 10 cycles.
    always @(negedge clk) begin
        if (i_reset) begin
            busy_cnt = 0;
            i_tx_busy = 1'b0;
        end else begin
            i_tx_busy = (busy_cnt > 0);
            if (busy_cnt > 0) busy_cnt--;
            if (o_tx_start && tx_enable) busy_cnt = 10;
        end
    end

    task automatic do_reset();
        @(negedge clk);
        #2 i_reset = 1'b1;
        cmp_en = 1'b1;
        #1;
        chk("rst_tx_start", 64'(o_tx_start), 64'd0);
        chk("rst_tx_word", 64'(o_tx_word), 64'd0);
        chk("rst_tx_slave", 64'(o_tx_slave), 64'd0);
        chk("rst_overflow", 64'(o_overflow), 64'd0);
        @(negedge clk);
        @(negedge clk);
        #2 i_reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic strobe(input logic [N-1:0] mask, input logic [31:0] w0, input logic [31:0] w1,
                          input logic [31:0] w2, input logic [31:0] w3, output int t);
        i_slave_nonce = {w3, w2, w1, w0};
        i_slave_new_nonce = mask;
        t = cyc;
        @(negedge clk);
        i_slave_new_nonce = '0;
    endtask

    task automatic wait_cyc(input int c);
        int guard = 0;
        while (cyc < c && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
    endtask

    task automatic chk_start(input string tag, input int idx, input int slave, input logic [31:0] word, input int at);
        if (idx >= st_slave.size()) begin
            checks++;
            errors++;
            $display("FAIL %s: start %0d missing, got %0d starts expected more", tag, idx, st_slave.size());
        end else begin
            chk({tag, "_slave"}, 64'(st_slave[idx]), 64'(slave));
            chk({tag, "_word"}, 64'(st_word[idx]), 64'(word));
            chk({tag, "_cycle"}, 64'(st_cyc[idx]), 64'(at));
        end
    endtask

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: got timeout expected finish");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        int t, t2, base;
        do_reset();

        // Single nonce: start two cycles after the strobe.
        base = st_slave.size();
        strobe(4'b0100, 32'h0, 32'h0, 32'hDEADBEEF, 32'h0, t);
        wait_cyc(t + 25);
        chk("t1_count", 64'(st_slave.size() - base), 64'd1);
        chk_start("t1", base, 2, 32'hDEADBEEF, t + 2);
        chk("t1_overflow", 64'(o_overflow), 64'd0);

        // Three simultaneous strobes are served in round-robin order, 13 cycles apart.
        do_reset();
        base = st_slave.size();
        strobe(4'b1011, 32'h11111111, 32'h22222222, 32'h0, 32'h33333333, t);
        wait_cyc(t + 45);
        chk("t2_count", 64'(st_slave.size() - base), 64'd3);
        chk_start("t2a", base, 0, 32'h11111111, t + 2);
        chk_start("t2b", base + 1, 1, 32'h22222222, t + 15);
        chk_start("t2c", base + 2, 3, 32'h33333333, t + 28);

        // Second strobe while the slot is pending is dropped and flagged.
        do_reset();
        base = st_slave.size();
        strobe(4'b0001, 32'h00000100, 32'h0, 32'h0, 32'h0, t);
        wait_cyc(t + 5);
        strobe(4'b0010, 32'h0, 32'h0000000A, 32'h0, 32'h0, t2);
        wait_cyc(t + 8);
        strobe(4'b0010, 32'h0, 32'h0000000B, 32'h0, 32'h0, t2);
        wait_cyc(t + 35);
        chk("t3_count", 64'(st_slave.size() - base), 64'd2);
        chk_start("t3a", base, 0, 32'h00000100, t + 2);
        chk_start("t3b", base + 1, 1, 32'h0000000A, t + 15);
        chk("t3_overflow", 64'(o_overflow), 64'(4'b0010));

        // A strobe in the grant cycle refills the slot without overflow.
        do_reset();
        base = st_slave.size();
        strobe(4'b0001, 32'h00000100, 32'h0, 32'h0, 32'h0, t);
        wait_cyc(t + 5);
        strobe(4'b0010, 32'h0, 32'h0000000A, 32'h0, 32'h0, t2);
        wait_cyc(t + 14);
        strobe(4'b0010, 32'h0, 32'h0000000C, 32'h0, 32'h0, t2);
        wait_cyc(t + 45);
        chk("t4_count", 64'(st_slave.size() - base), 64'd3);
        chk_start("t4a", base, 0, 32'h00000100, t + 2);
        chk_start("t4b", base + 1, 1, 32'h0000000A, t + 15);
        chk_start("t4c", base + 2, 1, 32'h0000000C, t + 28);
        chk("t4_overflow", 64'(o_overflow), 64'd0);

        // Busy never rises: the handshake times out and the next slave is granted.
        do_reset();
        tx_enable = 1'b0;
        base = st_slave.size();
        strobe(4'b0101, 32'h00000055, 32'h0, 32'h00000077, 32'h0, t);
        wait_cyc(t + 45);
        chk("t5_count", 64'(st_slave.size() - base), 64'd2);
        chk_start("t5a", base, 0, 32'h00000055, t + 2);
        chk_start("t5b", base + 1, 2, 32'h00000077, t + 19);
        tx_enable = 1'b1;

        // Reset while the transmitter is busy and two slaves are pending.
        do_reset();
        strobe(4'b0001, 32'h00000600, 32'h0, 32'h0, 32'h0, t);
        wait_cyc(t + 4);
        strobe(4'b0110, 32'h0, 32'h00000611, 32'h00000622, 32'h0, t2);
        chk("t6_word_before_reset", 64'(o_tx_word), 64'h600);
        do_reset();
        base = st_slave.size();
        repeat (30) @(negedge clk);
        chk("t6_no_start_after_reset", 64'(st_slave.size() - base), 64'd0);
        strobe(4'b1000, 32'h0, 32'h0, 32'h0, 32'h00000633, t2);
        wait_cyc(t2 + 20);
        chk("t6_count", 64'(st_slave.size() - base), 64'd1);
        chk_start("t6", base, 3, 32'h00000633, t2 + 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
